rd_uart_tx: RTL and testbench
=============================

Name: rd_uart_tx

Overview:
Downstream stage of the Wishbone read path. Captures each completed read (master strobe, read, slave ack) and buffers the byte in a small FIFO. Serialises buffered bytes as 8N1 frames on the host return line (RX1 at the top level). Sits beside the bus master, consuming the multiplexed slave dat/ack.

Parameters:
CLK_DIV, 16, clk_i cycles per UART bit; legal range 2..65535.
DEPTH, 16, FIFO entries; power of two, 2..256.
AW, 4, FIFO pointer width; equals log2(DEPTH).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  asynchronous, active-low reset.
stb_i  in  1  Wishbone master strobe, observed on the bus.
we_i  in  1  Wishbone write enable; 1 = write, which is ignored.
ack_i  in  1  muxed slave acknowledge.
dat_i  in  8  muxed slave read data.
clr_ovf  in  1  synchronous clear of the sticky overflow flag.
txd  out  1  serial output, idle high.
busy  out  1  high while a frame is in flight or the FIFO is non-empty.
ovf  out  1  sticky flag: a read byte was dropped because the FIFO was full.
level  out  AW+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_i=0, asynchronous): txd=1, busy=0, ovf=0, level=0, pointers=0, FSM=IDLE, baud counter=0.
- Capture rule: cap = stb_i & ~we_i & ack_i & ~ack_q. ack_q is ack_i registered. Exactly one byte per ack rising edge, even if ack is held for several cycles.
- Push on cap. If full and no pop in the same cycle: byte dropped, ovf set on the next edge.
- Push and pop in the same cycle: both happen, level unchanged. This holds when full (push accepted) and when level=1.
- Empty FIFO with a push: no bypass. The byte is written at edge N and popped no earlier than edge N+1.
- clr_ovf and an overflow event in the same cycle: set wins.
- level: registered count. +1 on a push only, -1 on a pop only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level!=0, pop into shreg, baud counter = CLK_DIV-1, bit index = 0, go to START. txd=1.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: txd=shreg[0]. Shift right on each bit end. 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: txd=1 for CLK_DIV cycles, then return to IDLE.
- Bit end: baud counter == 0. On a bit end the counter reloads CLK_DIV-1; otherwise it decrements. The counter is 16 bits.
- Back-to-back frames: IDLE lasts exactly one cycle between a STOP end and the next START. Frame period = 10*CLK_DIV + 1 cycles.
- Latency: cap at edge N, entry visible at N+1, pop at N+1 (if IDLE), txd falls after N+2.
- txd is driven from a register; no combinational path from inputs.
- busy = (state!=IDLE) | (level!=0).
- Pointers wrap modulo DEPTH. Full = level==DEPTH; empty = level==0.

Decomposition:
- Shared package: FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the UART frame constants (8 data bits, 1 stop bit).
- One sub-module, sync_fifo8: DEPTH x 8 register array with pointers and level.
- Capture logic and the TX FSM stay in rd_uart_tx.

Test Plan:
- Reset mid-frame: pull rst_i low during DATA -> txd=1, busy=0, level=0 immediately, with no clock edge required.
- Single read, CLK_DIV=4, dat_i=0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, then busy=0.
- ack_i held high 5 cycles with stb_i high, dat_i=0x3C -> exactly one frame; level peaks at 1.
- Write cycle (we_i=1, ack_i=1, dat_i=0xFF) -> no push, txd stays 1, level=0.
- DEPTH=4, CLK_DIV=100, 6 reads 0x01..0x06 in 12 cycles -> the first byte is popped, level reaches 4 and ovf=1. Frames carry 0x01..0x05; 0x06 is dropped. After clr_ovf, ovf=0.
- Two queued bytes 0x00, 0xFF with CLK_DIV=2 -> second start bit begins exactly 1 cycle after the first stop bit ends (frame period 21 cycles).

Source files
------------

// File: rtl/rd_uart_tx_pkg.sv
// Shared definitions for the Wishbone read-return UART: FSM state codes,
// 8N1 frame constants and the line-level helper used by the transmitter.
package rd_uart_tx_pkg;

    // Transmitter FSM encodings (legacy-compatible two-bit codes)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // 8N1 framing
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Serial line level for a given FSM state: low for start, the current
    // shift-register LSB for data, high for stop and idle.
    function automatic logic line_level(input logic [1:0] st, input logic lsb);
        logic lvl;
        lvl = 1'b1;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = lsb;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/rd_uart_tx_sync_fifo8.sv
// DEPTH x 8 synchronous FIFO with registered occupancy. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; the read
// port is combinational from the read pointer, so no bypass path exists
// from din to dout.
module sync_fifo8 #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          accept
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_rd;

    assign full   = (level == LEVEL_FULL);
    assign empty  = (level == '0);
    assign do_rd  = pop & ~empty;
    assign accept = push & (~full | do_rd);
    assign dout   = mem[rd_ptr];

    // Storage array: data only, no reset needed
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: changes only when exactly one of push/pop takes effect
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            level <= '0;
        end else begin
            case ({accept, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rd_uart_tx.sv
// Read-return UART: captures every completed Wishbone read byte (one per
// rising edge of the slave ack), queues it, and sends it as an 8N1 frame on
// txd. The line is driven from a register one cycle behind the FSM state,
// so the first falling edge appears two edges after the capture edge.
module rd_uart_tx
    import rd_uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 16,
    parameter int AW      = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic          ack_i,
    input  logic [7:0]    dat_i,
    input  logic          clr_ovf,
    output logic          txd,
    output logic          busy,
    output logic          ovf,
    output logic [AW:0]   level
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_DATA   = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);

    logic        ack_q;
    logic        cap;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_accept;
    logic [7:0]  fifo_dout;
    logic [1:0]  state;
    logic [15:0] baud_cnt;
    logic        bit_end;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        txd_q;

    // One capture per ack rising edge of a read cycle
    assign cap     = stb_i & ~we_i & ack_i & ~ack_q;
    assign pop     = (state == ST_IDLE) & ~fifo_empty;
    assign bit_end = (baud_cnt == 16'd0);
    assign busy    = (state != ST_IDLE) | ~fifo_empty;
    assign txd     = txd_q;

    sync_fifo8 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (cap),
        .pop    (pop),
        .din    (dat_i),
        .dout   (fifo_dout),
        .level  (level),
        .empty  (fifo_empty),
        .accept (fifo_accept)
    );

    // Delayed ack for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_i;
        end
    end

    // Sticky overflow: a dropped byte sets it and wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf <= 1'b0;
        end else if (cap & ~fifo_accept) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    // Baud counter: loaded on frame start, reloads at every bit end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            baud_cnt <= 16'd0;
        end else if (state == ST_IDLE) begin
            if (pop) baud_cnt <= BAUD_RELOAD;
        end else if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    // Frame sequencer: START -> DATA x8 -> STOP, one IDLE cycle between frames
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state   <= ST_START;
                        bit_idx <= 3'd0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_DATA) begin
                            state   <= ST_STOP;
                            bit_idx <= 3'd0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP) begin
                            state   <= ST_IDLE;
                            bit_idx <= 3'd0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

    // Shift register: loaded on pop, shifted right at each data bit end
    always_ff @(posedge clk_i) begin
        if (pop) begin
            shreg <= fifo_dout;
        end else if ((state == ST_DATA) && bit_end) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    // Registered line driver, idle high
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            txd_q <= 1'b1;
        end else begin
            txd_q <= line_level(state, shreg[0]);
        end
    end

endmodule

// File: tb/tb_rd_uart_tx.sv
// Directed bench for rd_uart_tx. Three instances cover the parameter sets
// used by the scenarios: A (CLK_DIV=4, DEPTH=16), B (CLK_DIV=100, DEPTH=4)
// and C (CLK_DIV=2, DEPTH=16). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_rd_uart_tx;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [2:0] stb, we, ack, clr;
    logic [7:0] dat [3];
    logic [2:0] txd, busy, ovf;
    logic [4:0] level_a;
    logic [2:0] level_b;
    logic [4:0] level_c;

    int n_cmp = 0;
    int n_bad = 0;
    int pk;

    always #5 clk = ~clk;

    rd_uart_tx #(.CLK_DIV(4), .DEPTH(16), .AW(4)) u_a (
        .clk_i(clk), .rst_i(rst_i), .stb_i(stb[0]), .we_i(we[0]), .ack_i(ack[0]),
        .dat_i(dat[0]), .clr_ovf(clr[0]), .txd(txd[0]), .busy(busy[0]),
        .ovf(ovf[0]), .level(level_a));

    rd_uart_tx #(.CLK_DIV(100), .DEPTH(4), .AW(2)) u_b (
        .clk_i(clk), .rst_i(rst_i), .stb_i(stb[1]), .we_i(we[1]), .ack_i(ack[1]),
        .dat_i(dat[1]), .clr_ovf(clr[1]), .txd(txd[1]), .busy(busy[1]),
        .ovf(ovf[1]), .level(level_b));

    rd_uart_tx #(.CLK_DIV(2), .DEPTH(16), .AW(4)) u_c (
        .clk_i(clk), .rst_i(rst_i), .stb_i(stb[2]), .we_i(we[2]), .ack_i(ack[2]),
        .dat_i(dat[2]), .clr_ovf(clr[2]), .txd(txd[2]), .busy(busy[2]),
        .ovf(ovf[2]), .level(level_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level of bit j of an 8N1 frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    // One read cycle: ack high for one cycle, then low for one cycle
    task automatic do_read(input int idx, input logic [7:0] d);
        stb[idx] = 1'b1; we[idx] = 1'b0; ack[idx] = 1'b1; dat[idx] = d;
        @(negedge clk);
        stb[idx] = 1'b0; ack[idx] = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a start bit, then sample each bit mid-cell.
    // Returns at the last sample of the stop bit.
    task automatic rx_frame(input int idx, input int div, input logic [7:0] d, input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        int waited;
        waited = 0;
        while (txd[idx] !== 1'b0 && waited < 40*div + 100) begin
            @(negedge clk);
            waited++;
        end
        if (txd[idx] !== 1'b0) begin
            chk({tag, "_start_timeout"}, 32'(txd[idx]), 32'd0);
            return;
        end
        obs = '0;
        for (int k = 0; k < 10*div; k++) begin
            if (k > 0) @(negedge clk);
            if (k % div == div/2) obs[k/div] = txd[idx];
        end
        for (int j = 0; j < 10; j++) exp[j] = frame_bit(d, j);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_frame;
        int errs, lows, maxl, bsy;

        rst_i = 1'b0;
        stb = '0; we = '0; ack = '0; clr = '0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;

        // Reset state
        #12;
        chk("rst_txd", 32'(txd), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_level_a", 32'(level_a), 32'd0);
        chk("rst_level_b", 32'(level_b), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // Single read 0xA5 at CLK_DIV=4: exact per-cycle line check
        a5_frame = 10'h34A;  // bits 0..9: 0,1,0,1,0,0,1,0,1,1
        do_read(0, 8'hA5);
        chk("a5_line_before_start", 32'(txd[0]), 32'd1);
        chk("a5_busy_in_frame", 32'(busy[0]), 32'd1);
        chk("a5_level_after_pop", 32'(level_a), 32'd0);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (txd[0] !== a5_frame[k/4]) errs++;
        end
        chk("a5_bit_cells", 32'(errs), 32'd0);
        chk("a5_busy_after", 32'(busy[0]), 32'd0);
        lows = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
        end
        chk("a5_idle_after", 32'(lows), 32'd0);

        // Held ack: one frame only, level never above 1
        pk = 0;
        fork
            begin
                stb[0] = 1'b1; we[0] = 1'b0; ack[0] = 1'b1; dat[0] = 8'h3C;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (int'(level_a) > pk) pk = int'(level_a);
                end
                stb[0] = 1'b0; ack[0] = 1'b0;
            end
            rx_frame(0, 4, 8'h3C, "held_frame");
        join
        chk("held_level_peak", 32'(pk), 32'd1);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
        end
        chk("held_single_frame", 32'(lows), 32'd0);
        chk("held_busy_after", 32'(busy[0]), 32'd0);

        // Write cycle is ignored
        stb[0] = 1'b1; we[0] = 1'b1; ack[0] = 1'b1; dat[0] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        stb[0] = 1'b0; we[0] = 1'b0; ack[0] = 1'b0;
        lows = 0; maxl = 0; bsy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
            if (int'(level_a) > maxl) maxl = int'(level_a);
            if (busy[0] !== 1'b0) bsy++;
        end
        chk("wr_txd_idle", 32'(lows), 32'd0);
        chk("wr_level", 32'(maxl), 32'd0);
        chk("wr_busy", 32'(bsy), 32'd0);

        // Overflow with DEPTH=4, CLK_DIV=100
        fork
            begin
                for (int i = 1; i <= 6; i++) do_read(1, 8'(i));
                chk("ovf_level_full", 32'(level_b), 32'd4);
                chk("ovf_set", 32'(ovf[1]), 32'd1);
                stb[1] = 1'b1; ack[1] = 1'b1; dat[1] = 8'h07; clr[1] = 1'b1;
                @(negedge clk);
                stb[1] = 1'b0; ack[1] = 1'b0; clr[1] = 1'b0;
                chk("ovf_set_wins", 32'(ovf[1]), 32'd1);
                chk("ovf_drop_level", 32'(level_b), 32'd4);
                @(negedge clk);
                clr[1] = 1'b1;
                @(negedge clk);
                clr[1] = 1'b0;
                chk("ovf_cleared", 32'(ovf[1]), 32'd0);
            end
            begin
                for (int i = 1; i <= 5; i++)
                    rx_frame(1, 100, 8'(i), $sformatf("ovf_frame%0d", i));
            end
        join
        chk("ovf_busy_end", 32'(busy[1]), 32'd0);
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (txd[1] !== 1'b1) lows++;
        end
        chk("ovf_no_sixth_frame", 32'(lows), 32'd0);
        chk("ovf_level_end", 32'(level_b), 32'd0);

        // Back-to-back frames at CLK_DIV=2: one idle cycle between frames
        fork
            begin
                do_read(2, 8'h00);
                do_read(2, 8'hFF);
            end
            begin
                rx_frame(2, 2, 8'h00, "b2b_first");
                @(negedge clk);
                chk("b2b_idle_gap", 32'(txd[2]), 32'd1);
                @(negedge clk);
                chk("b2b_next_start", 32'(txd[2]), 32'd0);
                rx_frame(2, 2, 8'hFF, "b2b_second");
            end
        join
        @(negedge clk);
        chk("b2b_busy_end", 32'(busy[2]), 32'd0);
        chk("b2b_level_end", 32'(level_c), 32'd0);

        // Asynchronous reset in the middle of a data bit
        do_read(0, 8'h5A);
        repeat (8) @(negedge clk);
        chk("rst_mid_pre_busy", 32'(busy[0]), 32'd1);
        chk("rst_mid_pre_txd", 32'(txd[0]), 32'd0);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_level", 32'(level_a), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
